// File: rtl/mem_access_unit.sv
// mem_access_unit
// Memory stage of an RV32I pipeline. It takes the EX-stage ALU result, which is
// either an effective address or write-back data, and handles byte, half and
// word loads and stores over a request/grant/response data-memory port. It
// presents registered write-back data to WB. Memory transactions stall
// upstream through a 3-state FSM. Other instructions pass through in one cycle.
//
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   ex_*                   instruction from EX (sampled only while stall=0)
//   stall                  upstream must hold its outputs
//   dmem_req/we/addr/      data-memory request channel, held stable until gnt
//     wdata/wstrb, dmem_gnt
//   dmem_rvalid/rdata      load response
//   wb_valid/we/rd/data    registered write-back, one pulse per instruction
//   fault                  one-cycle pulse for a misaligned or illegal memory op
module mem_access_unit (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ex_valid,
    input  logic        ex_mem_read,
    input  logic        ex_mem_write,
    input  logic [2:0]  ex_funct3,
    input  logic [31:0] ex_result,
    input  logic [31:0] ex_store_data,
    input  logic [4:0]  ex_rd,
    input  logic        ex_reg_we,
    output logic        stall,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_wstrb,
    input  logic        dmem_gnt,
    input  logic        dmem_rvalid,
    input  logic [31:0] dmem_rdata,
    output logic        wb_valid,
    output logic        wb_we,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data,
    output logic        fault
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

    state_t      state_q;
    logic        dmem_req_q, dmem_we_q;
    logic [31:0] dmem_addr_q, dmem_wdata_q;
    logic [3:0]  dmem_wstrb_q;
    logic        wb_valid_q, wb_we_q, fault_q;
    logic [4:0]  wb_rd_q;
    logic [31:0] wb_data_q;
    // Context of the outstanding transaction, needed to format load data
    logic [2:0]  funct3_q;
    logic [1:0]  off_q;
    logic [4:0]  rd_q;
    logic        reg_we_q;
    logic        is_store_q;

    // Misalignment or unsupported funct3 for the requested access kind
    function automatic logic mem_fault(input logic is_store, input logic [2:0] f3,
                                       input logic [1:0] off);
        logic bad;
        bad = 1'b1;
        case (f3)
            3'b000: bad = 1'b0;
            3'b001: bad = off[0];
            3'b010: bad = (off != 2'b00);
            3'b100: bad = is_store;
            3'b101: bad = is_store | off[0];
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

    function automatic logic [3:0] store_strb(input logic [2:0] f3, input logic [1:0] off);
        logic [3:0] s;
        case (f3)
            3'b000:  s = 4'b0001 << off;
            3'b001:  s = off[1] ? 4'b1100 : 4'b0011;
            default: s = 4'b1111;
        endcase
        return s;
    endfunction

    function automatic logic [31:0] store_lanes(input logic [2:0] f3, input logic [31:0] sd);
        logic [31:0] w;
        case (f3)
            3'b000:  w = {4{sd[7:0]}};
            3'b001:  w = {2{sd[15:0]}};
            default: w = sd;
        endcase
        return w;
    endfunction

    // Shift the addressed byte/half down to bit 0, then extend per funct3
    function automatic logic [31:0] load_format(input logic [2:0] f3, input logic [1:0] off,
                                                input logic [31:0] rdata);
        logic [31:0] lane;
        logic [31:0] r;
        lane = rdata >> {off, 3'b000};
        case (f3)
            3'b000:  r = {{24{lane[7]}}, lane[7:0]};
            3'b001:  r = {{16{lane[15]}}, lane[15:0]};
            3'b100:  r = {24'd0, lane[7:0]};
            3'b101:  r = {16'd0, lane[15:0]};
            default: r = lane;
        endcase
        return r;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            dmem_req_q   <= 1'b0;
            dmem_we_q    <= 1'b0;
            dmem_addr_q  <= 32'd0;
            dmem_wdata_q <= 32'd0;
            dmem_wstrb_q <= 4'b0000;
            wb_valid_q   <= 1'b0;
            wb_we_q      <= 1'b0;
            wb_rd_q      <= 5'd0;
            wb_data_q    <= 32'd0;
            fault_q      <= 1'b0;
            funct3_q     <= 3'd0;
            off_q        <= 2'd0;
            rd_q         <= 5'd0;
            reg_we_q     <= 1'b0;
            is_store_q   <= 1'b0;
        end else begin
            // Retire and fault are single-cycle pulses unless re-asserted below
            wb_valid_q <= 1'b0;
            fault_q    <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (ex_valid) begin
                        if (!(ex_mem_read || ex_mem_write)) begin
                            wb_valid_q <= 1'b1;
                            wb_we_q    <= ex_reg_we & (ex_rd != 5'd0);
                            wb_rd_q    <= ex_rd;
                            wb_data_q  <= ex_result;
                        end else if (mem_fault(ex_mem_write, ex_funct3, ex_result[1:0])) begin
                            wb_valid_q <= 1'b1;
                            wb_we_q    <= 1'b0;
                            fault_q    <= 1'b1;
                        end else begin
                            funct3_q     <= ex_funct3;
                            off_q        <= ex_result[1:0];
                            rd_q         <= ex_rd;
                            reg_we_q     <= ex_reg_we;
                            is_store_q   <= ex_mem_write;
                            dmem_req_q   <= 1'b1;
                            dmem_we_q    <= ex_mem_write;
                            dmem_addr_q  <= {ex_result[31:2], 2'b00};
                            dmem_wdata_q <= ex_mem_write ? store_lanes(ex_funct3, ex_store_data)
                                                         : 32'd0;
                            dmem_wstrb_q <= ex_mem_write ? store_strb(ex_funct3, ex_result[1:0])
                                                         : 4'b0000;
                            state_q      <= REQ;
                        end
                    end
                end
                REQ: begin
                    if (dmem_gnt) begin
                        dmem_req_q <= 1'b0;
                        if (is_store_q) begin
                            wb_valid_q <= 1'b1;
                            wb_we_q    <= 1'b0;
                            state_q    <= IDLE;
                        end else begin
                            state_q <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (dmem_rvalid) begin
                        wb_valid_q <= 1'b1;
                        wb_we_q    <= reg_we_q & (rd_q != 5'd0);
                        wb_rd_q    <= rd_q;
                        wb_data_q  <= load_format(funct3_q, off_q, dmem_rdata);
                        state_q    <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign stall      = (state_q != IDLE);
    assign dmem_req   = dmem_req_q;
    assign dmem_we    = dmem_we_q;
    assign dmem_addr  = dmem_addr_q;
    assign dmem_wdata = dmem_wdata_q;
    assign dmem_wstrb = dmem_wstrb_q;
    assign wb_valid   = wb_valid_q;
    assign wb_we      = wb_we_q;
    assign wb_rd      = wb_rd_q;
    assign wb_data    = wb_data_q;
    assign fault      = fault_q;

endmodule

// File: tb/tb_mem_access_unit.sv
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ex_valid = 1'b0, ex_mem_read = 1'b0, ex_mem_write = 1'b0;
    logic [2:0]  ex_funct3 = 3'd0;
    logic [31:0] ex_result = 32'd0, ex_store_data = 32'd0;
    logic [4:0]  ex_rd = 5'd0;
    logic        ex_reg_we = 1'b0;
    logic        stall, dmem_req, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata;
    logic [3:0]  dmem_wstrb;
    logic        dmem_gnt = 1'b0, dmem_rvalid = 1'b0;
    logic [31:0] dmem_rdata = 32'd0;
    logic        wb_valid, wb_we, fault;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;

    int checks = 0;
    int errors = 0;

    mem_access_unit dut (
        .clk(clk), .rst_n(rst_n),
        .ex_valid(ex_valid), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
        .ex_funct3(ex_funct3), .ex_result(ex_result), .ex_store_data(ex_store_data),
        .ex_rd(ex_rd), .ex_reg_we(ex_reg_we), .stall(stall),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_wstrb(dmem_wstrb), .dmem_gnt(dmem_gnt),
        .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
        .wb_valid(wb_valid), .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
        .fault(fault)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs are driven and outputs sampled 1ns after the edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic rd_op, input logic wr_op, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] sd,
                         input logic [4:0] rd, input logic we);
        ex_valid = 1'b1; ex_mem_read = rd_op; ex_mem_write = wr_op; ex_funct3 = f3;
        ex_result = addr; ex_store_data = sd; ex_rd = rd; ex_reg_we = we;
    endtask

    task automatic idle_inputs();
        ex_valid = 1'b0; ex_mem_read = 1'b0; ex_mem_write = 1'b0;
    endtask

    task automatic run_load(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                            input logic [4:0] rd, input logic [31:0] rdata,
                            input logic [31:0] exp_data, input logic exp_we);
        issue(1'b1, 1'b0, f3, addr, 32'd0, rd, 1'b1);
        step();
        idle_inputs();
        check({tag, "_req"}, dmem_req, 1);
        check({tag, "_addr"}, dmem_addr, {addr[31:2], 2'b00});
        check({tag, "_strb"}, dmem_wstrb, 0);
        dmem_gnt = 1'b1;
        step();
        dmem_gnt = 1'b0;
        check({tag, "_wait_stall"}, stall, 1);
        dmem_rvalid = 1'b1; dmem_rdata = rdata;
        step();
        dmem_rvalid = 1'b0;
        check({tag, "_wbv"}, wb_valid, 1);
        check({tag, "_data"}, wb_data, exp_data);
        check({tag, "_we"}, wb_we, exp_we);
        check({tag, "_rd"}, wb_rd, rd);
        check({tag, "_stall"}, stall, 0);
        step();
        check({tag, "_pulse"}, wb_valid, 0);
    endtask

    task automatic run_store(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                             input logic [31:0] sd, input logic [3:0] exp_strb,
                             input logic [31:0] exp_wdata);
        issue(1'b0, 1'b1, f3, addr, sd, 5'd0, 1'b0);
        step();
        idle_inputs();
        check({tag, "_req"}, dmem_req, 1);
        check({tag, "_we"}, dmem_we, 1);
        check({tag, "_strb"}, dmem_wstrb, exp_strb);
        check({tag, "_wdata"}, dmem_wdata, exp_wdata);
        dmem_gnt = 1'b1;
        step();
        dmem_gnt = 1'b0;
        check({tag, "_wbv"}, wb_valid, 1);
        check({tag, "_wbwe"}, wb_we, 0);
        check({tag, "_req_drop"}, dmem_req, 0);
    endtask

    task automatic run_fault(input string tag, input logic rd_op, input logic wr_op,
                             input logic [2:0] f3, input logic [31:0] addr);
        issue(rd_op, wr_op, f3, addr, 32'h1234_5678, 5'd3, 1'b1);
        step();
        idle_inputs();
        check({tag, "_fault"}, fault, 1);
        check({tag, "_wbv"}, wb_valid, 1);
        check({tag, "_wbwe"}, wb_we, 0);
        check({tag, "_noreq"}, dmem_req, 0);
        check({tag, "_stall"}, stall, 0);
        step();
        check({tag, "_fault_pulse"}, fault, 0);
        check({tag, "_wbv_pulse"}, wb_valid, 0);
        check({tag, "_noreq2"}, dmem_req, 0);
    endtask

    initial begin
        // Reset state
        #12;
        check("rst_stall", stall, 0);
        check("rst_req", dmem_req, 0);
        check("rst_wbv", wb_valid, 0);
        check("rst_fault", fault, 0);
        check("rst_strb", dmem_wstrb, 0);
        check("rst_addr", dmem_addr, 0);
        check("rst_wbdata", wb_data, 0);
        check("rst_wbrd", wb_rd, 0);
        rst_n = 1'b1;
        step();

        // Pass-through
        issue(1'b0, 1'b0, 3'd0, 32'h0000_1234, 32'd0, 5'd5, 1'b1);
        check("alu_stall_pre", stall, 0);
        step();
        idle_inputs();
        check("alu_wbv", wb_valid, 1);
        check("alu_we", wb_we, 1);
        check("alu_rd", wb_rd, 5);
        check("alu_data", wb_data, 32'h1234);
        check("alu_stall", stall, 0);
        step();
        check("alu_pulse", wb_valid, 0);

        // SB with grant after two wait cycles: request held for three cycles
        issue(1'b0, 1'b1, 3'b000, 32'h0000_0103, 32'hAABB_CCDD, 5'd0, 1'b0);
        step();
        idle_inputs();
        for (int i = 0; i < 3; i++) begin
            check("sb_req", dmem_req, 1);
            check("sb_addr", dmem_addr, 32'h100);
            check("sb_strb", dmem_wstrb, 4'b1000);
            check("sb_wdata", dmem_wdata, 32'hDDDD_DDDD);
            check("sb_stall", stall, 1);
            check("sb_nowb", wb_valid, 0);
            if (i == 2) dmem_gnt = 1'b1;
            step();
        end
        dmem_gnt = 1'b0;
        check("sb_wbv", wb_valid, 1);
        check("sb_wbwe", wb_we, 0);
        check("sb_stall_done", stall, 0);
        check("sb_req_drop", dmem_req, 0);

        run_store("sh", 3'b001, 32'h0000_0102, 32'hAABB_CCDD, 4'b1100, 32'hCCDD_CCDD);
        run_store("sw", 3'b010, 32'h0000_0104, 32'hAABB_CCDD, 4'b1111, 32'hAABB_CCDD);

        // Loads
        run_load("lb", 3'b000, 32'h0000_0202, 5'd4, 32'h0080_0000, 32'hFFFF_FF80, 1'b1);
        run_load("lbu", 3'b100, 32'h0000_0202, 5'd4, 32'h0080_0000, 32'h0000_0080, 1'b1);
        run_load("lh", 3'b001, 32'h0000_0202, 5'd6, 32'h8001_0000, 32'hFFFF_8001, 1'b1);
        run_load("lhu", 3'b101, 32'h0000_0202, 5'd6, 32'h8001_0000, 32'h0000_8001, 1'b1);
        run_load("lw_x0", 3'b010, 32'h0000_0204, 5'd0, 32'h1234_5678, 32'h1234_5678, 1'b0);

        // Faults
        run_fault("lw_mis", 1'b1, 1'b0, 3'b010, 32'h0000_0301);
        run_fault("sh_mis", 1'b0, 1'b1, 3'b001, 32'h0000_0001);
        run_fault("ld_f011", 1'b1, 1'b0, 3'b011, 32'h0000_0100);

        // Reset while a load is waiting for its response
        issue(1'b1, 1'b0, 3'b010, 32'h0000_0400, 32'd0, 5'd8, 1'b1);
        step();
        idle_inputs();
        dmem_gnt = 1'b1;
        step();
        dmem_gnt = 1'b0;
        check("rstw_stall_pre", stall, 1);
        #2 rst_n = 1'b0;
        #1;
        check("rstw_stall", stall, 0);
        check("rstw_req", dmem_req, 0);
        check("rstw_wbv", wb_valid, 0);
        step();
        rst_n = 1'b1;
        dmem_rvalid = 1'b1; dmem_rdata = 32'hDEAD_BEEF;
        step();
        dmem_rvalid = 1'b0;
        check("rstw_stray", wb_valid, 0);
        check("rstw_stray_data", wb_data, 0);

        // Reset while a store is requesting: request drops without a clock
        issue(1'b0, 1'b1, 3'b010, 32'h0000_0500, 32'h5555_AAAA, 5'd0, 1'b0);
        step();
        idle_inputs();
        check("rstr_req_pre", dmem_req, 1);
        #2 rst_n = 1'b0;
        #1;
        check("rstr_req", dmem_req, 0);
        check("rstr_stall", stall, 0);
        step();
        rst_n = 1'b1;
        step();

        // Back-to-back: ADD held under stall, accepted in the load's retire cycle
        issue(1'b1, 1'b0, 3'b010, 32'h0000_0600, 32'd0, 5'd7, 1'b1);
        step();
        issue(1'b0, 1'b0, 3'd0, 32'h0000_CAFE, 32'd0, 5'd9, 1'b1);
        dmem_gnt = 1'b1;
        step();
        dmem_gnt = 1'b0;
        check("b2b_stall", stall, 1);
        check("b2b_nowb", wb_valid, 0);
        dmem_rvalid = 1'b1; dmem_rdata = 32'h1122_3344;
        step();
        dmem_rvalid = 1'b0;
        check("b2b_ld_wbv", wb_valid, 1);
        check("b2b_ld_rd", wb_rd, 7);
        check("b2b_ld_data", wb_data, 32'h1122_3344);
        check("b2b_ld_stall", stall, 0);
        step();
        idle_inputs();
        check("b2b_add_wbv", wb_valid, 1);
        check("b2b_add_rd", wb_rd, 9);
        check("b2b_add_data", wb_data, 32'hCAFE);
        check("b2b_add_we", wb_we, 1);
        step();
        check("b2b_pulse", wb_valid, 0);
        check("b2b_noreq", dmem_req, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Memory stage of the RV32I pipeline, directly downstream of the EX stage: consumes the ALU result (used as an effective address or as pass-through write-back data) plus the store operand, performs byte/half/word loads and stores over a request/grant/response data-memory port, and presents registered write-back data to WB. Multi-cycle memory transactions stall the upstream pipeline through a 3-state FSM; non-memory instructions pass through with one cycle of latency.

## Interface
- No parameters (XLEN fixed at 32).
- clk  in  1  pipeline clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- ex_valid  in  1  instruction present at EX output
- ex_mem_read / ex_mem_write  in  1 / 1  load / store instruction (never both)
- ex_funct3  in  3  RV32I funct3: loads 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; stores 000 SB, 001 SH, 010 SW
- ex_result  in  32  ALU result: address for memory ops, write-back data otherwise
- ex_store_data  in  32  rs2 value for stores
- ex_rd  in  5  destination register; ex_reg_we  in  1  instruction writes rd
- stall  out  1  upstream must hold its outputs stable
- dmem_req  out  1; dmem_we  out  1; dmem_addr  out  32 (bits[1:0]=00); dmem_wdata  out  32; dmem_wstrb  out  4
- dmem_gnt  in  1  request accepted this cycle; dmem_rvalid  in  1; dmem_rdata  in  32
- wb_valid  out  1; wb_we  out  1; wb_rd  out  5; wb_data  out  32
- fault  out  1  one-cycle pulse, misaligned or illegal-funct3 memory op

## Operation
- States IDLE, REQ, WAIT. stall = (state != IDLE), combinational from state only.
- IDLE, ex_valid=0: wb_valid<=0, fault<=0.
- IDLE, ex_valid=1, non-memory: wb_valid<=1, wb_we<=ex_reg_we & (ex_rd!=0), wb_rd<=ex_rd, wb_data<=ex_result. Stay IDLE.
- IDLE, memory op, fault condition (LH/LHU/SH with addr[0]=1; LW/SW with addr[1:0]!=0; load funct3 011/110/111 or store funct3 >010): no bus request; wb_valid<=1, wb_we<=0, fault<=1. Stay IDLE.
- IDLE, legal memory op: latch funct3, addr[1:0], rd, reg_we, load/store; drive dmem_addr<={addr[31:2],2'b00}, dmem_we, dmem_wdata, dmem_wstrb; dmem_req<=1; wb_valid<=0; -> REQ.
- Store lanes: SB wdata={4{sd[7:0]}}, wstrb=4'b0001<<addr[1:0]; SH wdata={2{sd[15:0]}}, wstrb=addr[1]?1100:0011; SW wdata=sd, wstrb=1111. Loads: wstrb=0000.
- REQ: dmem_req and all dmem_* held stable until dmem_gnt=1. On gnt: dmem_req<=0; store -> IDLE with wb_valid<=1, wb_we<=0; load -> WAIT.
- WAIT: on dmem_rvalid: lane = rdata>>(8*addr[1:0]); LB/LH sign-extend lane[7:0]/lane[15:0], LBU/LHU zero-extend, LW full word; wb_data<=result, wb_rd<=rd, wb_we<=reg_we & (rd!=0), wb_valid<=1; -> IDLE.
- dmem_rvalid outside WAIT is ignored. dmem_gnt outside REQ is ignored.
- Inputs are sampled only in IDLE; while stall=1, ex_* are don't-care to this block.

## Timing
- Reset (async assert, sync deassert by system): state=IDLE; stall, dmem_req, dmem_we, fault, wb_valid, wb_we = 0; dmem_addr, dmem_wdata, wb_data = 0; dmem_wstrb=0000; wb_rd=0.
- Reset mid-transaction: FSM to IDLE, dmem_req drops immediately; any later rvalid for the killed load is ignored.
- Pass-through / fault latency: 1 cycle (accept at T, wb_valid at T+1).
- Store: accept T, dmem_req T+1; gnt at T+1+g -> wb_valid at T+2+g. Best case 2 cycles.
- Load: rvalid earliest one cycle after gnt. Accept T, gnt T+1, rvalid T+2 -> wb_valid T+3. Best case 3 cycles.
- stall is high from T+1 through the cycle rvalid (load) or gnt (store) is seen; falls the cycle wb_valid rises; a new instruction may be accepted in that same cycle.
- wb_valid is a single-cycle pulse per retired instruction; never two instructions retire in one cycle.

## Test plan
- Reset then non-memory op ex_result=0x0000_1234, rd=5, reg_we=1 -> next cycle wb_valid=1, wb_we=1, wb_rd=5, wb_data=0x1234, stall=0 throughout.
- SB addr=0x103, store_data=0xAABBCCDD, gnt after 2 wait cycles -> dmem_addr=0x100, wstrb=1000, wdata=0xDDDDDDDD held stable 3 cycles; stall high until gnt; wb_valid=1, wb_we=0.
- LB addr=0x202, rdata=0x0080_0000 -> wb_data=0xFFFFFF80; LBU same -> 0x00000080; LH addr=0x202 rdata=0x8001_0000 -> 0xFFFF8001; LW rd=0 -> wb_we=0.
- LW addr=0x301 -> no dmem_req ever, fault=1 and wb_valid=1 for one cycle, wb_we=0; same for SH addr=0x1 and load funct3=011.
- Load in WAIT, assert rst_n=0 -> dmem_req/stall/wb_valid 0 asynchronously; after reset a stray rvalid produces no wb_valid.
- Back-to-back: LW then ADD held under stall -> ADD accepted in the load's wb_valid cycle, retires exactly one cycle after the load.
